pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 112 +++++++++++
 tb/tb_pc_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// +----------------------------------------------------------------------------+
// | pc_sequencer : program-counter sequencer with jump/branch, IN-stall, halt  |
// |                and saturating retirement counter.                          |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module pc_sequencer #(
    parameter int          LAST_ADDR = 55,
    parameter logic [5:0]  OP_IN     = 6'b011111
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        jump,
    input  logic        branch_taken,
    input  logic [9:0]  target,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [9:0]  adress,
    output logic        halted,
    output logic [15:0] retired
);

    localparam logic [10:0] c_LAST_ADDR = 11'(LAST_ADDR);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        WAIT_IN = 2'd2,
        HALT    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  adress_q, adress_d;
    logic        halted_q, halted_d;
    logic [15:0] retired_q, retired_d;

    logic        w_is_in;
    logic        w_active;
    logic        w_retire;
    logic [10:0] w_cand;

    assign w_is_in  = (instruction[31:26] == OP_IN);
    assign w_active = (state_q == RUN) || (state_q == WAIT_IN);
    assign w_retire = w_active && (!w_is_in || in_valid);

    // Widened by one bit so the sequential increment past 1023 cannot wrap.
    always_comb begin
        if (jump)
            w_cand = {1'b0, target};
        else if (branch_taken)
            w_cand = {1'b0, target};
        else
            w_cand = {1'b0, adress_q} + 11'd1;
    end

    always_comb begin
        state_d   = state_q;
        adress_d  = adress_q;
        halted_d  = halted_q;
        retired_d = retired_q;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN, WAIT_IN: begin
                if (w_retire) begin
                    if (retired_q != 16'hFFFF)
                        retired_d = retired_q + 16'd1;
                    if (w_cand > c_LAST_ADDR) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d  = RUN;
                        adress_d = w_cand[9:0];
                    end
                end else begin
                    state_d = WAIT_IN;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= BOOT;
            adress_q  <= 10'd0;
            halted_q  <= 1'b0;
            retired_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            adress_q  <= adress_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    assign in_ready = w_active && w_is_in;
    assign adress   = adress_q;
    assign halted   = halted_q;
    assign retired  = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_pc_sequencer : directed self-checking bench for pc_sequencer.           |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pc_sequencer;

    localparam logic [31:0] c_NOP = 32'h0000_0000;
    localparam logic [31:0] c_IN  = {6'b011111, 26'h0};

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instruction = 32'h0;
    logic        jump = 1'b0;
    logic        branch_taken = 1'b0;
    logic [9:0]  target = 10'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [9:0]  adress;
    logic        halted;
    logic [15:0] retired;

    int total = 0;
    int bad   = 0;

    pc_sequencer #(.LAST_ADDR(55), .OP_IN(6'b011111)) dut (
        .clock        (clock),
        .reset        (reset),
        .instruction  (instruction),
        .jump         (jump),
        .branch_taken (branch_taken),
        .target       (target),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .adress       (adress),
        .halted       (halted),
        .retired      (retired)
    );

    always #5 clock = ~clock;

    // Advance one rising edge; outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        instruction = c_NOP; jump = 1'b0; branch_taken = 1'b0;
        target = 10'd0; in_valid = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        instruction = c_IN;
        #1;
        total++; if (adress !== 10'd0) begin bad++; $display("FAIL reset_adress got=%0d exp=0", adress); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
        total++; if (retired !== 16'd0) begin bad++; $display("FAIL reset_retired got=%0d exp=0", retired); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL boot_in_ready got=%b exp=0", in_ready); end
        instruction = c_NOP;
    endtask

    task automatic test_nop_stream();
        logic [9:0] exp_a [0:4];
        exp_a = '{10'd0, 10'd0, 10'd1, 10'd2, 10'd3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (adress !== exp_a[i]) begin
                bad++; $display("FAIL nop_adress[%0d] got=%0d exp=%0d", i, adress, exp_a[i]);
            end
            if (i < 4) step();
        end
        total++; if (retired !== 16'd3) begin bad++; $display("FAIL nop_retired got=%0d exp=3", retired); end
    endtask

    task automatic test_jump_branch();
        step(); step();
        total++; if (adress !== 10'd5) begin bad++; $display("FAIL pre_jump_adress got=%0d exp=5", adress); end
        jump = 1'b1; branch_taken = 1'b1; target = 10'd20;
        step();
        jump = 1'b0; branch_taken = 1'b0;
        total++; if (adress !== 10'd20) begin bad++; $display("FAIL jump_adress got=%0d exp=20", adress); end
        step();
        total++; if (adress !== 10'd21) begin bad++; $display("FAIL post_jump_adress got=%0d exp=21", adress); end
        branch_taken = 1'b1; target = 10'd7;
        step();
        branch_taken = 1'b0;
        total++; if (adress !== 10'd7) begin bad++; $display("FAIL branch_adress got=%0d exp=7", adress); end
        total++; if (retired !== 16'd8) begin bad++; $display("FAIL branch_retired got=%0d exp=8", retired); end
    endtask

    task automatic test_wait_in();
        do_reset();
        step(); step(); step(); step();
        instruction = c_IN; in_valid = 1'b0; jump = 1'b1; target = 10'd40;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL in_ready_run got=%b exp=1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (adress !== 10'd3 || retired !== 16'd3 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL wait_in[%0d] adress=%0d retired=%0d in_ready=%b exp 3/3/1",
                         i, adress, retired, in_ready);
            end
        end
        jump = 1'b0; in_valid = 1'b1;
        step();
        instruction = c_NOP; in_valid = 1'b0;
        total++; if (adress !== 10'd4) begin bad++; $display("FAIL in_accept_adress got=%0d exp=4", adress); end
        total++; if (retired !== 16'd4) begin bad++; $display("FAIL in_accept_retired got=%0d exp=4", retired); end
    endtask

    task automatic test_wait_reset();
        instruction = c_IN; in_valid = 1'b0;
        step();
        reset = 1'b0; jump = 1'b1; target = 10'd9; in_valid = 1'b1;
        step();
        jump = 1'b0; in_valid = 1'b0;
        total++;
        if (adress !== 10'd0 || in_ready !== 1'b0 || retired !== 16'd0) begin
            bad++;
            $display("FAIL wait_reset adress=%0d in_ready=%b retired=%0d exp 0/0/0", adress, in_ready, retired);
        end
        reset = 1'b1;
        step();
        total++;
        if (adress !== 10'd0 || in_ready !== 1'b1 || retired !== 16'd0) begin
            bad++;
            $display("FAIL boot_repeat adress=%0d in_ready=%b retired=%0d exp 0/1/0", adress, in_ready, retired);
        end
        instruction = c_NOP;
    endtask

    task automatic test_halt();
        do_reset();
        step();
        for (int i = 0; i < 55; i++) step();
        total++;
        if (adress !== 10'd55 || halted !== 1'b0 || retired !== 16'd55) begin
            bad++;
            $display("FAIL pre_halt adress=%0d halted=%b retired=%0d exp 55/0/55", adress, halted, retired);
        end
        step();
        total++;
        if (adress !== 10'd55 || halted !== 1'b1 || retired !== 16'd56) begin
            bad++;
            $display("FAIL halt adress=%0d halted=%b retired=%0d exp 55/1/56", adress, halted, retired);
        end
        instruction = c_IN; jump = 1'b1; target = 10'd0; in_valid = 1'b1;
        step(); step();
        total++;
        if (adress !== 10'd55 || halted !== 1'b1 || retired !== 16'd56 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL halt_frozen adress=%0d halted=%b retired=%0d in_ready=%b exp 55/1/56/0",
                     adress, halted, retired, in_ready);
        end
    endtask

    task automatic test_jump_halt();
        do_reset();
        step(); step(); step();
        jump = 1'b1; target = 10'd60;
        step();
        jump = 1'b0;
        total++;
        if (adress !== 10'd2 || halted !== 1'b1 || retired !== 16'd3) begin
            bad++;
            $display("FAIL jump_halt adress=%0d halted=%b retired=%0d exp 2/1/3", adress, halted, retired);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        step();
        jump = 1'b1; target = 10'd0;
        for (int i = 0; i < 65534; i++) step();
        total++; if (retired !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h exp=fffe", retired); end
        step();
        total++; if (retired !== 16'hFFFF) begin bad++; $display("FAIL sat_reach got=%h exp=ffff", retired); end
        step(); step();
        total++; if (retired !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", retired); end
        jump = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nop_stream();
        test_jump_branch();
        test_wait_in();
        test_wait_reset();
        test_halt();
        test_jump_halt();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
